msg_fifo_buf: RTL and testbench

//   Buffers messages from the message extractor (256-bit data + 32-bit byte mask, valid only,
//   no backpressure) in a first-word-fall-through FIFO and presents them to the downstream

---
 rtl/msg_fifo_buf.sv | 90 +++++++++
 tb/tb_msg_fifo_buf.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_fifo_buf.sv
// Message FIFO between the extractor and the downstream consumer.
// FWFT head, per-entry byte count, overflow drop counter.
module msg_fifo_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [255:0]     in_data,
  input  logic [31:0]      in_bytemask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [255:0]     out_data,
  output logic [31:0]      out_bytemask,
  output logic [5:0]       out_len,
  output logic [AW:0]      fill_level,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);

  logic [255:0] mem_data [DEPTH];
  logic [31:0]  mem_mask [DEPTH];
  logic [5:0]   mem_len  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [5:0]    in_len;
  logic          push;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          drop;

  always_comb begin
    in_len = '0;
    for (int i = 0; i < 32; i++) begin
      in_len = in_len + 6'(in_bytemask[i]);
    end
  end

  assign push    = in_valid && (in_bytemask != '0);
  assign full    = fill_level == (AW+1)'(DEPTH);
  assign pop     = out_valid && out_ready;
  // A pop on a full FIFO frees the slot the push lands in.
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fill_level <= fill_level
                  + (AW+1)'(push_ok)
                  - (AW+1)'(pop);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) begin
          drop_count <= drop_count + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem_data[wr_ptr] <= in_data;
      mem_mask[wr_ptr] <= in_bytemask;
      mem_len[wr_ptr]  <= in_len;
    end
  end

  // Head is read combinationally; an empty FIFO shows zeros.
  assign out_valid    = fill_level != '0;
  assign out_data     = out_valid ? mem_data[rd_ptr] : '0;
  assign out_bytemask = out_valid ? mem_mask[rd_ptr] : '0;
  assign out_len      = out_valid ? mem_len[rd_ptr]  : '0;

endmodule

// File: tb/tb_msg_fifo_buf.sv
// Bench for msg_fifo_buf: directed scenarios plus random traffic
// checked against a queue-based model of the message buffer.
module tb_msg_fifo_buf;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [255:0] in_data = '0;
  logic [31:0]  in_bytemask = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] out_data;
  logic [31:0]  out_bytemask;
  logic [5:0]   out_len;
  logic [3:0]   fill_level;
  logic [15:0]  drop_count;
  logic         overflow;

  msg_fifo_buf #(.DEPTH(8), .AW(3), .CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_bytemask(in_bytemask),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_bytemask(out_bytemask),
    .out_len(out_len),
    .fill_level(fill_level),
    .drop_count(drop_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] d;
    logic [31:0]  m;
  } ent_t;

  ent_t mq[$];
  int   exp_drops = 0;
  bit   exp_ovf = 0;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [255:0] rnd_data();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [31:0] rnd_mask();
    logic [31:0] m;
    m = $urandom;
    if (m == 0) m = 32'h1;
    return m;
  endfunction

  // Drive one cycle and advance the model by the buffer's rules.
  task automatic step(input logic v, input logic [255:0] d,
                      input logic [31:0] m, input logic rdy);
    bit pop, push;
    ent_t e;
    in_valid = v;
    in_data = d;
    in_bytemask = m;
    out_ready = rdy;
    pop = (mq.size() != 0) && rdy;
    push = v && (m != 0);
    @(posedge clk);
    #1;
    if (push && mq.size() == DEPTH && !pop) begin
      if (exp_drops < 65535) exp_drops++;
      exp_ovf = 1;
    end else begin
      if (pop) mq.delete(0);
      if (push) begin
        e.d = d;
        e.m = m;
        mq.push_back(e);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input logic v);
    reset = 1'b1;
    in_valid = v;
    in_bytemask = 32'h0000_000F;
    in_data = rnd_data();
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    mq.delete();
    exp_drops = 0;
    exp_ovf = 0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", out_valid);
    end
    checks++;
    if (fill_level !== 4'd0 || drop_count !== 16'd0
        || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d/%b want 0/0/0",
               fill_level, drop_count, overflow);
    end
    checks++;
    if (out_data !== '0 || out_bytemask !== '0
        || out_len !== 6'd0) begin
      errors++;
      $display("FAIL reset_out got %h/%h/%0d want zeros",
               out_data[31:0], out_bytemask, out_len);
    end
  endtask

  task automatic test_single();
    logic [255:0] d;
    d = rnd_data();
    d[7:0] = 8'hA5;
    step(1'b1, d, 32'h0000_00FF, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_len !== 6'd8
        || out_data[7:0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_head got v=%b len=%0d b0=%h want 1/8/a5",
               out_valid, out_len, out_data[7:0]);
    end
    checks++;
    if (out_data !== d) begin
      errors++;
      $display("FAIL single_data got %h want %h", out_data, d);
    end
    step(1'b0, '0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_len();
    int dc;
    step(1'b1, rnd_data(), 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (out_len !== 6'd32) begin
      errors++;
      $display("FAIL len_full got %0d want 32", out_len);
    end
    step(1'b1, rnd_data(), 32'h8000_0001, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    checks++;
    if (out_len !== 6'd2 || out_bytemask !== 32'h8000_0001) begin
      errors++;
      $display("FAIL len_sparse got %0d/%h want 2/80000001",
               out_len, out_bytemask);
    end
    dc = drop_count;
    step(1'b1, rnd_data(), 32'h0, 1'b0);
    checks++;
    if (fill_level !== 4'd1 || drop_count !== 16'(dc)) begin
      errors++;
      $display("FAIL len_zero got fill=%0d drops=%0d want 1/%0d",
               fill_level, drop_count, dc);
    end
    step(1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_overflow();
    logic [255:0] d;
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      d = rnd_data();
      d[7:0] = 8'(i);
      step(1'b1, d, rnd_mask(), 1'b0);
    end
    checks++;
    if (fill_level !== 4'd8 || drop_count !== 16'd2
        || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_state got %0d/%0d/%b want 8/2/1",
               fill_level, drop_count, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data[7:0] !== 8'(i)
          || out_data !== mq[0].d) begin
        errors++;
        $display("FAIL ovf_order got v=%b tag=%0d want 1/%0d",
                 out_valid, out_data[7:0], i);
      end
      step(1'b0, '0, '0, 1'b1);
    end
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain got v=%b ovf=%b want 0/1",
               out_valid, overflow);
    end
  endtask

  task automatic test_full_wrap();
    do_reset(1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, rnd_data(), rnd_mask(), 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (fill_level !== 4'd8 || drop_count !== 16'd0
          || out_data !== mq[0].d
          || out_bytemask !== mq[0].m) begin
        errors++;
        $display("FAIL wrap_c%0d got fill=%0d drops=%0d d=%h want 8/0/%h",
                 i, fill_level, drop_count, out_data[31:0],
                 mq[0].d[31:0]);
      end
      step(1'b1, rnd_data(), rnd_mask(), 1'b1);
    end
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_backpressure();
    ent_t h;
    step(1'b1, rnd_data(), rnd_mask(), 1'b0);
    step(1'b1, rnd_data(), rnd_mask(), 1'b0);
    h = mq[0];
    for (int i = 0; i < 5; i++) begin
      step(1'b1, rnd_data(), rnd_mask(), 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== h.d
          || out_bytemask !== h.m
          || out_len !== 6'($countones(h.m))) begin
        errors++;
        $display("FAIL hold_c%0d got %h/%h/%0d want %h/%h/%0d",
                 i, out_data[31:0], out_bytemask, out_len,
                 h.d[31:0], h.m, $countones(h.m));
      end
    end
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] m;
    logic        rdy;
    int          bad = 0;
    do_reset(1'b0);
    for (int i = 0; i < 400; i++) begin
      m = ($urandom % 8 == 0) ? 32'h0 : rnd_mask();
      rdy = (i < 200) ? ($urandom % 3 == 0) : ($urandom % 3 != 0);
      step($urandom % 4 != 0, rnd_data(), m, rdy);
      checks++;
      if (out_valid !== (mq.size() != 0)
          || fill_level !== 4'(mq.size())
          || drop_count !== 16'(exp_drops)
          || overflow !== exp_ovf) begin
        errors++;
        if (bad++ < 5)
          $display("FAIL rand_state c%0d got %b/%0d/%0d/%b want %b/%0d/%0d/%b",
                   i, out_valid, fill_level, drop_count, overflow,
                   mq.size() != 0, mq.size(), exp_drops, exp_ovf);
      end else if (mq.size() != 0) begin
        checks++;
        if (out_data !== mq[0].d || out_bytemask !== mq[0].m
            || out_len !== 6'($countones(mq[0].m))) begin
          errors++;
          if (bad++ < 5)
            $display("FAIL rand_head c%0d got %h/%h/%0d want %h/%h/%0d",
                     i, out_data[31:0], out_bytemask, out_len,
                     mq[0].d[31:0], mq[0].m, $countones(mq[0].m));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int i = 0; i < 11; i++) begin
      step(1'b1, rnd_data(), rnd_mask(), 1'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1);
    checks++;
    if (fill_level !== 4'd5 || drop_count !== 16'd3) begin
      errors++;
      $display("FAIL mid_pre got %0d/%0d want 5/3",
               fill_level, drop_count);
    end
    do_reset(1'b1);
    checks++;
    if (out_valid !== 1'b0 || fill_level !== 4'd0
        || drop_count !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got %b/%0d/%0d/%b want 0/0/0/0",
               out_valid, fill_level, drop_count, overflow);
    end
    step(1'b0, '0, '0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || fill_level !== 4'd0) begin
      errors++;
      $display("FAIL mid_after got %b/%0d want 0/0",
               out_valid, fill_level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_len();
    test_overflow();
    test_full_wrap();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
